// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SimpRisc memory-port arbiter: FSM states, requester ids and access direction.
package simprisc_mem_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_WAIT, ARB_RESP} arb_state_e;

  typedef enum logic {REQ_IF, REQ_D} req_id_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_picker.sv
// Combinational winner select between fetch and load/store requests.
// Tie-break: fixed D priority by default; round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_picker
  import simprisc_mem_pkg::*;
(
  input  logic    if_req,
  input  logic    d_req,
  input  req_id_e last_grant,
  output logic    valid,
  output req_id_e winner
);

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that was not granted last goes next.
  always_comb begin
    valid  = if_req | d_req;
    winner = REQ_D;
    if (if_req && d_req) begin
      winner = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
    end else if (if_req) begin
      winner = REQ_IF;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == REQ_D);

  // Load/store always wins a tie so the pipeline never stalls behind fetch.
  always_comb begin
    valid  = if_req | d_req;
    winner = REQ_D;
    if (if_req && !d_req) begin
      winner = REQ_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; all outputs registered.
// Tie-break selected by MEM_ARB_RR_EN (see mem_arb_picker).
module mem_port_arbiter
  import simprisc_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e        state_reg, state_next;
  req_id_e           winner_reg, last_grant_reg, pick_winner;
  logic              pick_valid;
  logic [CNT_W-1:0]  cnt_reg;

  logic              go, capture;
  logic              if_gnt_next, d_gnt_next, if_rvalid_next, d_rvalid_next;
  logic              mem_en_next, mem_rw_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next, if_rdata_next, d_rdata_next;

  mem_arb_picker u_picker (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ARB_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:   if (pick_valid) state_next = ARB_ACCESS;
      ARB_ACCESS: state_next = (mem_rw == MEM_WRITE) ? ARB_IDLE : ARB_WAIT;
      ARB_WAIT:   if (cnt_reg == '0) state_next = ARB_RESP;
      ARB_RESP:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // Output values are computed one cycle ahead and registered below.
  always_comb begin
    go             = (state_reg == ARB_IDLE) && pick_valid;
    capture        = (state_reg == ARB_WAIT) && (cnt_reg == '0);
    if_gnt_next    = go && (pick_winner == REQ_IF);
    d_gnt_next     = go && (pick_winner == REQ_D);
    mem_en_next    = go;
    mem_rw_next    = d_gnt_next ? d_rw : MEM_READ;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    if (go) mem_addr_next = (pick_winner == REQ_D) ? d_addr : if_addr;
    if (d_gnt_next && d_rw == MEM_WRITE) mem_wdata_next = d_wdata;
    if_rvalid_next = capture && (winner_reg == REQ_IF);
    d_rvalid_next  = capture && (winner_reg == REQ_D);
    if_rdata_next  = if_rvalid_next ? mem_rdata : if_rdata;
    d_rdata_next   = d_rvalid_next  ? mem_rdata : d_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_gnt         <= 1'b0;
      d_gnt          <= 1'b0;
      if_rvalid      <= 1'b0;
      d_rvalid       <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      mem_en         <= 1'b0;
      mem_rw         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      winner_reg     <= REQ_IF;
      last_grant_reg <= REQ_IF;
      cnt_reg        <= '0;
    end else begin
      if_gnt    <= if_gnt_next;
      d_gnt     <= d_gnt_next;
      if_rvalid <= if_rvalid_next;
      d_rvalid  <= d_rvalid_next;
      if_rdata  <= if_rdata_next;
      d_rdata   <= d_rdata_next;
      mem_en    <= mem_en_next;
      mem_rw    <= mem_rw_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      if (go) winner_reg <= pick_winner;
      if (state_reg == ARB_ACCESS) begin
        last_grant_reg <= winner_reg;
        cnt_reg        <= CNT_W'(RD_LAT - 1);
      end else if (state_reg == ARB_WAIT && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (RD_LAT=2) with a latency-accurate memory model.
// Tie expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
  import simprisc_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_rw = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_rw;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [133:0]  outs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    req_id_e     id;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] rd_q[$];

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                 mem_en, mem_rw, mem_addr, mem_wdata};

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: read data is valid exactly RL cycles after the mem_en cycle, garbage otherwise.
  logic [31:0] pipe_d [RL] = '{default: 32'h0};
  logic        pipe_v [RL] = '{default: 1'b0};
  always @(posedge clk) begin
    pipe_v[0] <= mem_en && (mem_rw == MEM_READ);
    pipe_d[0] <= mem_val(mem_addr);
    for (int i = 1; i < RL; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign mem_rdata = pipe_v[RL-1] ? pipe_d[RL-1] : 32'h0BAD_0BAD;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_after_reset: got %h want 0", outs); end
    $display("reset: outputs=%h", outs);
  endtask

  task automatic test_single_read();
    acc_t e;
    logic [31:0] d;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    acc_q.push_back('{REQ_IF, MEM_READ, 32'h0000_0040, 32'h0});
    rd_q.push_back(mem_val(32'h0000_0040));
    @(negedge clk);
    e = acc_q.pop_front();
    checks++;
    if ({mem_en, if_gnt, d_gnt, mem_rw} !== {1'b1, 1'b1, 1'b0, e.rw}) begin
      errors++; $display("FAIL read_gnt: en/ig/dg/rw got %b%b%b%b want 110%b", mem_en, if_gnt, d_gnt, mem_rw, e.rw);
    end
    checks++;
    if (mem_addr !== e.addr || mem_wdata !== e.wdata) begin
      errors++; $display("FAIL read_addr: got %h/%h want %h/%h", mem_addr, mem_wdata, e.addr, e.wdata);
    end
    if_req = 1'b0; if_addr = '0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (if_rvalid !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL read_early: rvalid=%b mem_en=%b want 0 0", if_rvalid, mem_en);
      end
    end
    @(negedge clk);
    d = rd_q.pop_front();
    checks++;
    if (if_rvalid !== 1'b1) begin errors++; $display("FAIL read_rvalid: got %b want 1", if_rvalid); end
    checks++;
    if (if_rdata !== d) begin errors++; $display("FAIL read_data: got %h want %h", if_rdata, d); end
    $display("read  IF addr=%h data=%h", e.addr, if_rdata);
    @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b0) begin errors++; $display("FAIL read_pulse: rvalid got %b want 0", if_rvalid); end
  endtask

  task automatic test_write();
    acc_t e;
    bit   bad = 1'b0;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    acc_q.push_back('{REQ_D, MEM_WRITE, 32'h200, 32'h1234_5678});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = acc_q.pop_front();
      checks++;
      if ({mem_en, d_gnt, if_gnt, mem_rw} !== {1'b1, 1'b1, 1'b0, e.rw}) begin
        errors++; $display("FAIL write_gnt%0d: en/dg/ig/rw got %b%b%b%b want 110%b", k, mem_en, d_gnt, if_gnt, mem_rw, e.rw);
      end
      checks++;
      if (mem_addr !== e.addr || mem_wdata !== e.wdata) begin
        errors++; $display("FAIL write_data%0d: got %h/%h want %h/%h", k, mem_addr, mem_wdata, e.addr, e.wdata);
      end
      $display("write D  addr=%h data=%h", mem_addr, mem_wdata);
      if (k == 0) begin
        // Keep the request up with a new write: it must be taken on the next IDLE visit.
        d_addr = 32'h204; d_wdata = 32'hCAFE_F00D;
        acc_q.push_back('{REQ_D, MEM_WRITE, 32'h204, 32'hCAFE_F00D});
        @(negedge clk);
        checks++;
        if ({mem_en, mem_rw, d_gnt} !== 3'b000 || mem_wdata !== '0) begin
          errors++; $display("FAIL write_gap: en/rw/gnt got %b%b%b wdata %h want 000 0", mem_en, mem_rw, d_gnt, mem_wdata);
        end
      end
    end
    d_req = 1'b0; d_rw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (d_rvalid !== 1'b0 || mem_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL write_no_rvalid: d_rvalid/mem_en seen after write, want none"); end
  endtask

  task automatic test_reset_mid_wait();
    acc_t e;
    bit   bad = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    acc_q.push_back('{REQ_IF, MEM_READ, 32'h100, 32'h0});
    @(negedge clk);
    e = acc_q.pop_front();
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== e.addr) begin
      errors++; $display("FAIL rst_pre_gnt: gnt=%b addr=%h want 1 %h", if_gnt, mem_addr, e.addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rst_async_outs: got %h want 0", outs); end
    $display("reset mid-wait: outputs=%h", outs);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if_rvalid !== 1'b0 || mem_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rst_no_rvalid: activity after abandoned read, want none"); end
    if_req = 1'b1; if_addr = 32'h104;
    acc_q.push_back('{REQ_IF, MEM_READ, 32'h104, 32'h0});
    rd_q.push_back(mem_val(32'h104));
    @(negedge clk);
    e = acc_q.pop_front();
    checks++;
    if (if_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== e.addr) begin
      errors++; $display("FAIL rst_idle_gnt: gnt=%b en=%b addr=%h want 1 1 %h", if_gnt, mem_en, mem_addr, e.addr);
    end
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== rd_q[0]) begin
      errors++; $display("FAIL rst_reread: rvalid=%b data=%h want 1 %h", if_rvalid, if_rdata, rd_q[0]);
    end
    $display("read  IF addr=%h data=%h (after reset)", e.addr, if_rdata);
    void'(rd_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_tie();
    acc_t        e;
    req_id_e     got;
    logic [31:0] ia = 32'h300, da = 32'h400;
    int          ni = 0, nd = 0, n;
    for (int k = 0; k < 6; k++) begin
      acc_t x;
`ifdef MEM_ARB_RR_EN
      x.id = (k % 2 == 0) ? REQ_D : REQ_IF;
`else
      x.id = (k < 3) ? REQ_D : REQ_IF;
`endif
      x.rw = MEM_READ; x.wdata = '0;
      if (x.id == REQ_D) begin x.addr = da + 32'(4 * nd); nd++; end
      else               begin x.addr = ia + 32'(4 * ni); ni++; end
      acc_q.push_back(x);
    end
    nd = 0; ni = 0;
    if_req = 1'b1; d_req = 1'b1; d_rw = 1'b0; if_addr = ia; d_addr = da;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!(if_gnt || d_gnt) && n < 20);
      checks++;
      if (!(if_gnt || d_gnt) || acc_q.size() == 0) begin
        errors++; $display("FAIL tie_timeout%0d: no grant within 20 cycles", k);
        break;
      end
      e = acc_q.pop_front();
      got = d_gnt ? REQ_D : REQ_IF;
      if (got !== e.id || mem_addr !== e.addr) begin
        errors++; $display("FAIL tie_grant%0d: got %s addr %h want %s addr %h", k, got.name(), mem_addr, e.id.name(), e.addr);
      end
      $display("tie   grant%0d %s addr=%h", k, got.name(), mem_addr);
      if (got == REQ_D) begin
        nd++; if (nd == 3) d_req = 1'b0; else d_addr = d_addr + 32'd4;
      end else begin
        ni++; if (ni == 3) if_req = 1'b0; else if_addr = if_addr + 32'd4;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!(if_rvalid || d_rvalid) && n < 20);
      checks++;
      if ((got == REQ_D ? {d_rvalid, if_rvalid} : {if_rvalid, d_rvalid}) !== 2'b10 ||
          (got == REQ_D ? d_rdata : if_rdata) !== mem_val(e.addr)) begin
        errors++; $display("FAIL tie_data%0d: rv if/d=%b%b data if=%h d=%h want %s %h", k, if_rvalid, d_rvalid, if_rdata, d_rdata, e.id.name(), mem_val(e.addr));
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_late_request();
    acc_t e;
    if_req = 1'b1; if_addr = 32'h500;
    acc_q.push_back('{REQ_IF, MEM_READ, 32'h500, 32'h0});
    rd_q.push_back(mem_val(32'h500));
    @(negedge clk);
    e = acc_q.pop_front();
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== e.addr) begin
      errors++; $display("FAIL late_if_gnt: gnt=%b addr=%h want 1 %h", if_gnt, mem_addr, e.addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h600;
    acc_q.push_back('{REQ_D, MEM_READ, 32'h600, 32'h0});
    rd_q.push_back(mem_val(32'h600));
    repeat (2) @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== rd_q[0] || d_gnt !== 1'b0) begin
      errors++; $display("FAIL late_if_resp: rvalid=%b data=%h dgnt=%b want 1 %h 0", if_rvalid, if_rdata, d_gnt, rd_q[0]);
    end
    $display("read  IF addr=%h data=%h", e.addr, if_rdata);
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL late_idle: dgnt=%b en=%b want 0 0", d_gnt, mem_en);
    end
    @(negedge clk);
    e = acc_q.pop_front();
    checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== e.addr) begin
      errors++; $display("FAIL late_d_gnt: gnt=%b en=%b addr=%h want 1 1 %h", d_gnt, mem_en, mem_addr, e.addr);
    end
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== rd_q[1] || if_rdata !== rd_q[0]) begin
      errors++; $display("FAIL late_d_resp: rvalid=%b d=%h if=%h want 1 %h %h", d_rvalid, d_rdata, if_rdata, rd_q[1], rd_q[0]);
    end
    $display("read  D  addr=%h data=%h", e.addr, d_rdata);
    rd_q.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_reset_mid_wait();
    test_tie();
    test_late_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
